data_sampling: RTL and testbench

Oversampling front end of the UART receiver, sitting directly upstream of the start-bit checker (`strt_chk`) and the parity/stop checkers. It synchronises the raw serial line and runs the edge (oversample) and bit counters for the RX FSM. It takes three samples around the centre of each bit and majority-votes them into `sampled_bit`, with a one-cycle `samp_valid` strobe. `samp_valid` marks when the FSM may pulse `strt_chk_en` (or the other check enables) against a settled `sampled_bit`.

---
 rtl/data_sampling_if.sv | 15 +
 rtl/data_sampling.sv | 57 +++++
 tb/tb_data_sampling.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/data_sampling_if.sv
// data_sampling_if: RX FSM <-> oversampling front-end signal bundle
interface data_sampling_if #(parameter int PRESCALE_W = 6, parameter int BIT_CNT_W = 4);
  logic                  RX_IN;
  logic [PRESCALE_W-1:0] prescale;
  logic                  cnt_en;
  logic                  dat_samp_en;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  sampled_bit;
  logic                  samp_valid;
  modport master (output RX_IN, prescale, cnt_en, dat_samp_en,
                  input  edge_cnt, bit_cnt, sampled_bit, samp_valid);
  modport slave  (input  RX_IN, prescale, cnt_en, dat_samp_en,
                  output edge_cnt, bit_cnt, sampled_bit, samp_valid);
endinterface

// File: rtl/data_sampling.sv
// data_sampling: UART RX synchroniser, edge/bit counters and 3-sample majority vote
module data_sampling #(
  parameter int PRESCALE_W  = 6,
  parameter int BIT_CNT_W   = 4,
  parameter int SYNC_STAGES = 2
) (
  input logic CLK,
  input logic RST,
  data_sampling_if.slave b
);
  localparam logic [PRESCALE_W-1:0] one = PRESCALE_W'(1);
  logic [SYNC_STAGES-1:0] sync;
  logic [PRESCALE_W-1:0]  ps, h, p_even, ps_next;
  logic                   rx_s, en, s0, s1, maj;
  always_comb begin
    rx_s    = sync[SYNC_STAGES-1];
    h       = ps >> 1;
    p_even  = b.prescale & ~one;
    ps_next = p_even < PRESCALE_W'(4) ? PRESCALE_W'(4) : p_even;
    en      = b.cnt_en & b.dat_samp_en;
    maj     = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync          <= '1;
      ps            <= PRESCALE_W'(8);
      b.edge_cnt    <= '0;
      b.bit_cnt     <= '0;
      s0            <= 1'b1;
      s1            <= 1'b1;
      b.sampled_bit <= 1'b1;
      b.samp_valid  <= 1'b0;
    end else begin
      sync         <= {sync[SYNC_STAGES-2:0], b.RX_IN};
      b.samp_valid <= en && b.edge_cnt == h + one;
      if (!b.cnt_en) begin
        ps         <= ps_next;
        b.edge_cnt <= '0;
        b.bit_cnt  <= '0;
      end else if (b.edge_cnt == ps - one) begin
        b.edge_cnt <= '0;
        b.bit_cnt  <= b.bit_cnt + BIT_CNT_W'(1);
      end else begin
        b.edge_cnt <= b.edge_cnt + one;
      end
      // dropping either enable throws away any partially collected samples
      if (!en) begin
        s0 <= 1'b1;
        s1 <= 1'b1;
      end else begin
        if (b.edge_cnt == h - one) s0 <= rx_s;
        if (b.edge_cnt == h) s1 <= rx_s;
        if (b.edge_cnt == h + one) b.sampled_bit <= maj;
      end
    end
  end
endmodule

// File: tb/tb_data_sampling.sv
// tb_data_sampling: randomized and directed checks of data_sampling against a frame-position model
module tb_data_sampling;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int fails = 0;
  data_sampling_if #(.PRESCALE_W(6), .BIT_CNT_W(4)) bus();
  data_sampling #(.PRESCALE_W(6), .BIT_CNT_W(4), .SYNC_STAGES(2)) dut (.CLK(clk), .RST(rst), .b(bus));
  always #5 clk = ~clk;

  int m_pos, m_ps;
  bit m_s0, m_s1, m_sb, m_sv;
  bit hist[$];

  function automatic int cond(int p);
    p = p & ~1;
    return p < 4 ? 4 : p;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_ps = 8; m_s0 = 1; m_s1 = 1; m_sb = 1; m_sv = 0;
    hist.delete();
    for (int i = 0; i < 2; i++) hist.push_back(1'b1);
  endtask

  function automatic logic [11:0] exp_vec();
    return {6'(m_pos % m_ps), 4'((m_pos / m_ps) % 16), m_sb, m_sv};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {bus.edge_cnt, bus.bit_cnt, bus.sampled_bit, bus.samp_valid};
  endfunction

  task automatic tick();
    bit rx, en;
    int e, h;
    rx = hist[0];
    e  = m_pos % m_ps;
    h  = m_ps / 2;
    en = bus.cnt_en && bus.dat_samp_en;
    m_sv = en && e == h + 1;
    if (m_sv) m_sb = (int'(m_s0) + int'(m_s1) + int'(rx)) >= 2;
    if (!en) begin m_s0 = 1; m_s1 = 1; end
    else begin
      if (e == h - 1) m_s0 = rx;
      if (e == h) m_s1 = rx;
    end
    if (bus.cnt_en) m_pos++;
    else begin m_pos = 0; m_ps = cond(int'(bus.prescale)); end
    void'(hist.pop_front());
    hist.push_back(bus.RX_IN);
    @(posedge clk);
    if (rst) model_reset();
    #1;
  endtask

  task automatic idle(input int p, input int n);
    bus.cnt_en = 0; bus.dat_samp_en = 0; bus.RX_IN = 1; bus.prescale = 6'(p);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    idle(16, 3);
    bus.cnt_en = 1;
    for (int k = 0; k < 9; k++) tick();
    total++;
    if (bus.edge_cnt !== 6'd9) begin fails++; $display("FAIL pre_reset_edge: got %0d expected 9", bus.edge_cnt); end
    #2 rst = 1;
    #1 model_reset();
    total++;
    if (dut_vec() !== {6'd0, 4'd0, 1'b1, 1'b0})
      begin fails++; $display("FAIL async_reset: got %h expected %h", dut_vec(), {6'd0, 4'd0, 1'b1, 1'b0}); end
    tick();
    rst = 0;
    idle(8, 3);
  endtask

  task automatic test_counter_wrap();
    idle(8, 2);
    bus.cnt_en = 1;
    for (int k = 1; k <= 24; k++) begin
      tick();
      total++;
      if ({bus.edge_cnt, bus.bit_cnt} !== {6'(k % 8), 4'(k / 8)} || dut_vec() !== exp_vec())
        begin fails++; $display("FAIL wrap_clk%0d: got %h expected %h", k, dut_vec(), exp_vec()); end
    end
    bus.cnt_en = 0;
    tick();
    total++;
    if ({bus.edge_cnt, bus.bit_cnt} !== 10'd0)
      begin fails++; $display("FAIL wrap_clear: got %h expected 0", {bus.edge_cnt, bus.bit_cnt}); end
  endtask

  function automatic bit want_maj(int k);
    int e = k % 8;
    bit first = k < 8;
    if (e == 3) return first ? 1'b0 : 1'b1;
    if (e == 4) return first ? 1'b1 : 1'b0;
    if (e == 5) return first ? 1'b0 : 1'b1;
    return 1'b1;
  endfunction

  task automatic test_majority();
    idle(8, 3);
    bus.cnt_en = 1; bus.dat_samp_en = 1;
    for (int k = 0; k < 16; k++) begin
      bus.RX_IN = want_maj(k + 2);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL maj_model_k%0d: got %h expected %h", k, dut_vec(), exp_vec()); end
      if (k == 5) begin
        total++;
        if ({bus.edge_cnt, bus.sampled_bit, bus.samp_valid} !== {6'd6, 1'b0, 1'b1})
          begin fails++; $display("FAIL maj_010: got %h expected %h", {bus.edge_cnt, bus.sampled_bit, bus.samp_valid}, {6'd6, 1'b0, 1'b1}); end
      end
      if (k == 13) begin
        total++;
        if ({bus.sampled_bit, bus.samp_valid} !== 2'b11)
          begin fails++; $display("FAIL maj_101: got %b expected 11", {bus.sampled_bit, bus.samp_valid}); end
      end
    end
  endtask

  task automatic test_start_bit();
    for (int g = 0; g < 2; g++) begin
      idle(16, 4);
      bus.cnt_en = 1; bus.dat_samp_en = 1;
      for (int k = 0; k < 16; k++) begin
        bus.RX_IN = g == 0 ? 1'b0 : (k == 0 ? 1'b0 : 1'b1);
        tick();
        total++;
        if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL start_model_g%0d_k%0d: got %h expected %h", g, k, dut_vec(), exp_vec()); end
        if (k == 9) begin
          total++;
          if ({bus.edge_cnt, bus.sampled_bit, bus.samp_valid} !== {6'd10, g == 1, 1'b1})
            begin fails++; $display("FAIL start_vote_g%0d: got %h expected %h", g, {bus.edge_cnt, bus.sampled_bit, bus.samp_valid}, {6'd10, g == 1, 1'b1}); end
        end
      end
    end
  endtask

  task automatic test_prescale();
    idle(16, 2);
    bus.cnt_en = 1;
    for (int k = 1; k <= 20; k++) begin
      if (k == 3) bus.prescale = 6'd32;
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL ps_hold_k%0d: got %h expected %h", k, dut_vec(), exp_vec()); end
      if (k == 16) begin
        total++;
        if ({bus.edge_cnt, bus.bit_cnt} !== {6'd0, 4'd1})
          begin fails++; $display("FAIL ps_hold_wrap: got %h expected %h", {bus.edge_cnt, bus.bit_cnt}, {6'd0, 4'd1}); end
      end
    end
    bus.cnt_en = 0; tick();
    bus.cnt_en = 1;
    for (int k = 0; k < 16; k++) tick();
    total++;
    if (bus.edge_cnt !== 6'd16) begin fails++; $display("FAIL ps_new32: got %0d expected 16", bus.edge_cnt); end
    for (int g = 0; g < 2; g++) begin
      idle(g == 0 ? 5 : 2, 2);
      bus.cnt_en = 1; bus.dat_samp_en = 1;
      for (int k = 1; k <= 8; k++) begin
        tick();
        total++;
        if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL ps_small_g%0d_k%0d: got %h expected %h", g, k, dut_vec(), exp_vec()); end
        if (k == 4) begin
          total++;
          if ({bus.edge_cnt, bus.bit_cnt, bus.samp_valid} !== {6'd0, 4'd1, 1'b1})
            begin fails++; $display("FAIL ps_small_wrap_g%0d: got %h expected %h", g, {bus.edge_cnt, bus.bit_cnt, bus.samp_valid}, {6'd0, 4'd1, 1'b1}); end
        end
      end
    end
  endtask

  task automatic test_early_disable();
    idle(8, 3);
    bus.cnt_en = 1;
    for (int k = 0; k < 24; k++) begin
      bus.RX_IN = k < 6 ? 1'b0 : 1'b1;
      bus.dat_samp_en = !(k >= 12 && k < 16);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL early_model_k%0d: got %h expected %h", k, dut_vec(), exp_vec()); end
      if (k == 13) begin
        total++;
        if ({bus.sampled_bit, bus.samp_valid} !== 2'b00)
          begin fails++; $display("FAIL early_no_strobe: got %b expected 00", {bus.sampled_bit, bus.samp_valid}); end
      end
      if (k == 21) begin
        total++;
        if ({bus.sampled_bit, bus.samp_valid} !== 2'b11)
          begin fails++; $display("FAIL early_reenable: got %b expected 11", {bus.sampled_bit, bus.samp_valid}); end
      end
    end
  endtask

  task automatic test_random();
    int strobes = 0;
    idle(16, 3);
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) bus.RX_IN = ~bus.RX_IN;
      if ($urandom_range(0, 31) == 0) bus.prescale = 6'($urandom_range(0, 40));
      if (bus.cnt_en) bus.cnt_en = $urandom_range(0, 63) != 0;
      else bus.cnt_en = $urandom_range(0, 3) == 0;
      if (!bus.cnt_en || m_pos % m_ps == m_ps - 1) bus.dat_samp_en = $urandom_range(0, 3) != 0;
      tick();
      strobes += m_sv;
      total++;
      if (dut_vec() !== exp_vec()) begin fails++; $display("FAIL random_k%0d: got %h expected %h", k, dut_vec(), exp_vec()); end
    end
    total++;
    if (strobes < 20) begin fails++; $display("FAIL random_activity: got %0d strobes expected >= 20", strobes); end
  endtask

  initial begin
    bus.RX_IN = 1; bus.prescale = 6'd8; bus.cnt_en = 0; bus.dat_samp_en = 0;
    model_reset();
    #12 rst = 0;
    #1;
    total++;
    if (dut_vec() !== {6'd0, 4'd0, 1'b1, 1'b0})
      begin fails++; $display("FAIL reset_state: got %h expected %h", dut_vec(), {6'd0, 4'd0, 1'b1, 1'b0}); end
    test_reset();
    test_counter_wrap();
    test_majority();
    test_start_bit();
    test_prescale();
    test_early_disable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", total, fails);
    $finish;
  end
endmodule
